// File: rtl/rtc_bus_sequencer_if.sv
// Bundle of request/handshake and multiplexed AD-bus signals between the
// output-register bank, the RTC bus sequencer and the top-level pad driver.
interface rtc_bus_sequencer_if;
    logic       arranque_inicio;
    logic       arranque_leer;
    logic       arranque_escribir;
    logic [7:0] direccion;
    logic [7:0] dato;
    logic [7:0] ad_in;
    logic       listo;
    logic       ocupado;
    logic [7:0] dato_leido;
    logic       cs_n;
    logic       rd_n;
    logic       wr_n;
    logic       a_d;
    logic [7:0] ad_out;
    logic       ad_oe;

    modport master (
        output arranque_inicio, arranque_leer, arranque_escribir, direccion, dato, ad_in,
        input  listo, ocupado, dato_leido, cs_n, rd_n, wr_n, a_d, ad_out, ad_oe
    );

    modport slave (
        input  arranque_inicio, arranque_leer, arranque_escribir, direccion, dato, ad_in,
        output listo, ocupado, dato_leido, cs_n, rd_n, wr_n, a_d, ad_out, ad_oe
    );
endinterface

// File: rtl/rtc_bus_sequencer.sv
// Runs one Intel-style multiplexed address/data RTC bus transaction (or the
// two-write init sequence) per accepted start level; all outputs registered.
module rtc_bus_sequencer #(
    parameter int         T_PHASE   = 10,
    parameter logic [7:0] INIT_ADDR = 8'h02,
    parameter logic [7:0] INIT_DATA = 8'h10
) (
    input  logic               clk,
    input  logic               rst,
    rtc_bus_sequencer_if.slave bus
);

    localparam int             CW     = (T_PHASE > 1) ? $clog2(T_PHASE) : 1;
    localparam logic [CW-1:0]  RELOAD = CW'(T_PHASE - 1);

    localparam logic [3:0] S_IDLE     = 4'd0;
    localparam logic [3:0] S_ADDR_SET = 4'd1;
    localparam logic [3:0] S_ADDR_STB = 4'd2;
    localparam logic [3:0] S_ADDR_HLD = 4'd3;
    localparam logic [3:0] S_DATA_SET = 4'd4;
    localparam logic [3:0] S_DATA_STB = 4'd5;
    localparam logic [3:0] S_DATA_HLD = 4'd6;
    localparam logic [3:0] S_GAP      = 4'd7;
    localparam logic [3:0] S_DONE     = 4'd8;
    localparam logic [3:0] S_RECOVER  = 4'd9;

    logic [3:0]    r_state;
    logic [CW-1:0] r_cnt;
    logic          r_wr;
    logic          r_init;
    logic          r_second;
    logic [7:0]    r_addr;
    logic [7:0]    r_data;

    logic          r_cs_n, r_rd_n, r_wr_n, r_a_d, r_ad_oe, r_listo, r_ocupado;
    logic [7:0]    r_ad_out;
    logic [7:0]    r_dato_leido;

    logic [3:0]    w_state_nxt;
    logic [CW-1:0] w_cnt_nxt;
    logic          w_wr_nxt, w_init_nxt, w_second_nxt;
    logic [7:0]    w_addr_nxt, w_data_nxt;
    logic          w_phase_end;
    logic          w_capture;

    logic          w_cs_n, w_rd_n, w_wr_n, w_a_d, w_ad_oe, w_listo, w_ocupado;
    logic [7:0]    w_ad_out;

    assign w_phase_end = (r_cnt == '0);
    assign w_capture   = (r_state == S_DATA_STB) && w_phase_end && !r_wr;

    always_comb begin
        w_state_nxt  = r_state;
        w_wr_nxt     = r_wr;
        w_init_nxt   = r_init;
        w_second_nxt = r_second;
        w_addr_nxt   = r_addr;
        w_data_nxt   = r_data;
        case (r_state)
            S_IDLE: begin
                if (bus.arranque_inicio) begin
                    w_state_nxt  = S_ADDR_SET;
                    w_wr_nxt     = 1'b1;
                    w_init_nxt   = 1'b1;
                    w_second_nxt = 1'b0;
                    w_addr_nxt   = INIT_ADDR;
                    w_data_nxt   = INIT_DATA;
                end else if (bus.arranque_escribir || bus.arranque_leer) begin
                    w_state_nxt  = S_ADDR_SET;
                    w_wr_nxt     = bus.arranque_escribir;
                    w_init_nxt   = 1'b0;
                    w_second_nxt = 1'b0;
                    w_addr_nxt   = bus.direccion;
                    w_data_nxt   = bus.dato;
                end
            end
            S_ADDR_SET: if (w_phase_end) w_state_nxt = S_ADDR_STB;
            S_ADDR_STB: if (w_phase_end) w_state_nxt = S_ADDR_HLD;
            S_ADDR_HLD: if (w_phase_end) w_state_nxt = S_DATA_SET;
            S_DATA_SET: if (w_phase_end) w_state_nxt = S_DATA_STB;
            S_DATA_STB: if (w_phase_end) w_state_nxt = S_DATA_HLD;
            S_DATA_HLD: begin
                // Init runs a second write of zero after a one-cycle chip-select release
                if (w_phase_end) begin
                    if (r_init && !r_second) begin
                        w_state_nxt  = S_GAP;
                        w_second_nxt = 1'b1;
                        w_data_nxt   = 8'h00;
                    end else begin
                        w_state_nxt  = S_DONE;
                    end
                end
            end
            S_GAP:     w_state_nxt = S_ADDR_SET;
            S_DONE:    w_state_nxt = S_RECOVER;
            S_RECOVER: w_state_nxt = S_IDLE;
            default:   w_state_nxt = S_IDLE;
        endcase

        if (w_state_nxt != r_state) begin
            w_cnt_nxt = RELOAD;
        end else if (w_phase_end) begin
            w_cnt_nxt = '0;
        end else begin
            w_cnt_nxt = r_cnt - 1'b1;
        end
    end

    // Bus outputs are decoded from the next state so the registered pins line up with the state
    always_comb begin
        w_cs_n    = 1'b1;
        w_rd_n    = 1'b1;
        w_wr_n    = 1'b1;
        w_a_d     = 1'b1;
        w_ad_oe   = 1'b0;
        w_ad_out  = 8'h00;
        w_listo   = 1'b0;
        w_ocupado = (w_state_nxt != S_IDLE);
        case (w_state_nxt)
            S_ADDR_SET, S_ADDR_STB, S_ADDR_HLD: begin
                w_cs_n   = 1'b0;
                w_a_d    = 1'b0;
                w_ad_oe  = 1'b1;
                w_ad_out = w_addr_nxt;
                w_wr_n   = (w_state_nxt != S_ADDR_STB);
            end
            S_DATA_SET, S_DATA_STB, S_DATA_HLD: begin
                w_cs_n   = 1'b0;
                w_ad_oe  = w_wr_nxt;
                w_ad_out = w_wr_nxt ? w_data_nxt : 8'h00;
                if (w_state_nxt == S_DATA_STB) begin
                    w_wr_n = ~w_wr_nxt;
                    w_rd_n = w_wr_nxt;
                end
            end
            S_DONE:  w_listo = 1'b1;
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state      <= S_IDLE;
            r_cnt        <= '0;
            r_wr         <= 1'b0;
            r_init       <= 1'b0;
            r_second     <= 1'b0;
            r_cs_n       <= 1'b1;
            r_rd_n       <= 1'b1;
            r_wr_n       <= 1'b1;
            r_a_d        <= 1'b1;
            r_ad_oe      <= 1'b0;
            r_ad_out     <= 8'h00;
            r_listo      <= 1'b0;
            r_ocupado    <= 1'b0;
            r_dato_leido <= 8'h00;
        end else begin
            r_state   <= w_state_nxt;
            r_cnt     <= w_cnt_nxt;
            r_wr      <= w_wr_nxt;
            r_init    <= w_init_nxt;
            r_second  <= w_second_nxt;
            r_cs_n    <= w_cs_n;
            r_rd_n    <= w_rd_n;
            r_wr_n    <= w_wr_n;
            r_a_d     <= w_a_d;
            r_ad_oe   <= w_ad_oe;
            r_ad_out  <= w_ad_out;
            r_listo   <= w_listo;
            r_ocupado <= w_ocupado;
            if (w_capture) r_dato_leido <= bus.ad_in;
        end
    end

    always_ff @(posedge clk) begin
        r_addr <= w_addr_nxt;
        r_data <= w_data_nxt;
    end

    assign bus.cs_n       = r_cs_n;
    assign bus.rd_n       = r_rd_n;
    assign bus.wr_n       = r_wr_n;
    assign bus.a_d        = r_a_d;
    assign bus.ad_oe      = r_ad_oe;
    assign bus.ad_out     = r_ad_out;
    assign bus.listo      = r_listo;
    assign bus.ocupado    = r_ocupado;
    assign bus.dato_leido = r_dato_leido;

endmodule

// File: tb/tb_rtc_bus_sequencer.sv
// Directed bench for rtc_bus_sequencer with T_PHASE=2: write, read, init
// priority, held start and asynchronous reset mid-transfer.
module tb_rtc_bus_sequencer;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    rtc_bus_sequencer_if b();

    rtc_bus_sequencer #(
        .T_PHASE  (2),
        .INIT_ADDR(8'h02),
        .INIT_DATA(8'h10)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(b)
    );

    int n_chk = 0;
    int n_bad = 0;
    int t     = 0;

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h (t=%0d)", tag, obs, exp, t);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        t++;
    endtask

    task automatic go_to(input int target);
        while (t < target) step();
    endtask

    task automatic kick();
        @(posedge clk);
        #1;
        t = 0;
    endtask

    // RTC model: drives read data only while it sees rd_n low
    always @(negedge clk) b.ad_in = b.rd_n ? 8'hFF : 8'hA7;

    always @(negedge clk) begin
        chk("no_overlap", 8'(b.rd_n | b.wr_n), 8'd1);
        chk("oe_in_read", 8'(~b.rd_n & b.ad_oe), 8'd0);
        chk("cs_with_strobe", 8'((~b.rd_n | ~b.wr_n) & b.cs_n), 8'd0);
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int np;
        int k;
        b.arranque_inicio   = 1'b0;
        b.arranque_leer     = 1'b0;
        b.arranque_escribir = 1'b0;
        b.direccion         = 8'h00;
        b.dato              = 8'h00;
        #1 rst = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_cs_n", 8'(b.cs_n), 8'd1);
        chk("rst_rd_n", 8'(b.rd_n), 8'd1);
        chk("rst_wr_n", 8'(b.wr_n), 8'd1);
        chk("rst_a_d", 8'(b.a_d), 8'd1);
        chk("rst_ad_oe", 8'(b.ad_oe), 8'd0);
        chk("rst_ad_out", b.ad_out, 8'h00);
        chk("rst_listo", 8'(b.listo), 8'd0);
        chk("rst_ocupado", 8'(b.ocupado), 8'd0);
        chk("rst_dato_leido", b.dato_leido, 8'h00);
        @(negedge clk) rst = 1'b1;
        repeat (2) @(posedge clk);

        // write 0x5A to 0x21
        @(negedge clk);
        b.arranque_escribir = 1'b1;
        b.direccion = 8'h21;
        b.dato      = 8'h5A;
        kick();
        chk("wr_ocupado", 8'(b.ocupado), 8'd1);
        chk("wr_aset_cs", 8'(b.cs_n), 8'd0);
        chk("wr_aset_ad", 8'(b.a_d), 8'd0);
        chk("wr_aset_bus", b.ad_out, 8'h21);
        chk("wr_aset_oe", 8'(b.ad_oe), 8'd1);
        chk("wr_aset_wr", 8'(b.wr_n), 8'd1);
        @(negedge clk);
        b.arranque_escribir = 1'b0;
        b.direccion = 8'hEE;
        b.dato      = 8'hEE;
        go_to(2);
        chk("wr_astb_wr", 8'(b.wr_n), 8'd0);
        chk("wr_astb_bus", b.ad_out, 8'h21);
        go_to(3);
        chk("wr_astb2_wr", 8'(b.wr_n), 8'd0);
        go_to(4);
        chk("wr_ahld_wr", 8'(b.wr_n), 8'd1);
        chk("wr_ahld_bus", b.ad_out, 8'h21);
        chk("wr_ahld_ad", 8'(b.a_d), 8'd0);
        go_to(6);
        chk("wr_dset_ad", 8'(b.a_d), 8'd1);
        chk("wr_dset_bus", b.ad_out, 8'h5A);
        chk("wr_dset_oe", 8'(b.ad_oe), 8'd1);
        chk("wr_dset_wr", 8'(b.wr_n), 8'd1);
        go_to(8);
        chk("wr_dstb_wr", 8'(b.wr_n), 8'd0);
        chk("wr_dstb_rd", 8'(b.rd_n), 8'd1);
        chk("wr_dstb_bus", b.ad_out, 8'h5A);
        go_to(10);
        chk("wr_dhld_wr", 8'(b.wr_n), 8'd1);
        chk("wr_dhld_cs", 8'(b.cs_n), 8'd0);
        chk("wr_dhld_bus", b.ad_out, 8'h5A);
        go_to(11);
        chk("wr_listo_early", 8'(b.listo), 8'd0);
        go_to(12);
        chk("wr_listo", 8'(b.listo), 8'd1);
        chk("wr_done_cs", 8'(b.cs_n), 8'd1);
        chk("wr_done_oe", 8'(b.ad_oe), 8'd0);
        chk("wr_done_ocupado", 8'(b.ocupado), 8'd1);
        chk("wr_dato_leido", b.dato_leido, 8'h00);
        go_to(13);
        chk("wr_recover_listo", 8'(b.listo), 8'd0);
        chk("wr_recover_ocupado", 8'(b.ocupado), 8'd1);
        go_to(14);
        chk("wr_idle_ocupado", 8'(b.ocupado), 8'd0);

        // read from 0x22
        @(negedge clk);
        b.arranque_leer = 1'b1;
        b.direccion = 8'h22;
        kick();
        chk("rd_aset_bus", b.ad_out, 8'h22);
        chk("rd_aset_ad", 8'(b.a_d), 8'd0);
        @(negedge clk) b.arranque_leer = 1'b0;
        go_to(6);
        chk("rd_dset_oe", 8'(b.ad_oe), 8'd0);
        chk("rd_dset_ad", 8'(b.a_d), 8'd1);
        chk("rd_dset_cs", 8'(b.cs_n), 8'd0);
        go_to(8);
        chk("rd_dstb_rd", 8'(b.rd_n), 8'd0);
        chk("rd_dstb_wr", 8'(b.wr_n), 8'd1);
        chk("rd_dstb_oe", 8'(b.ad_oe), 8'd0);
        chk("rd_before_capture", b.dato_leido, 8'h00);
        go_to(10);
        chk("rd_dhld_rd", 8'(b.rd_n), 8'd1);
        chk("rd_dato_leido", b.dato_leido, 8'hA7);
        np = 0;
        while (t < 16) begin
            step();
            if (b.listo) np++;
        end
        chk("rd_listo_count", 8'(np), 8'd1);
        chk("rd_dato_hold", b.dato_leido, 8'hA7);

        // all three starts together: init sequence wins
        @(negedge clk);
        b.arranque_inicio   = 1'b1;
        b.arranque_leer     = 1'b1;
        b.arranque_escribir = 1'b1;
        b.direccion = 8'h99;
        b.dato      = 8'h77;
        kick();
        chk("pr_w1_addr", b.ad_out, 8'h02);
        chk("pr_w1_ad", 8'(b.a_d), 8'd0);
        go_to(6);
        chk("pr_w1_data", b.ad_out, 8'h10);
        chk("pr_w1_oe", 8'(b.ad_oe), 8'd1);
        go_to(8);
        chk("pr_w1_wr", 8'(b.wr_n), 8'd0);
        chk("pr_w1_rd", 8'(b.rd_n), 8'd1);
        go_to(12);
        chk("pr_gap_cs", 8'(b.cs_n), 8'd1);
        chk("pr_gap_listo", 8'(b.listo), 8'd0);
        chk("pr_gap_ocupado", 8'(b.ocupado), 8'd1);
        go_to(13);
        chk("pr_w2_cs", 8'(b.cs_n), 8'd0);
        chk("pr_w2_addr", b.ad_out, 8'h02);
        go_to(19);
        chk("pr_w2_data", b.ad_out, 8'h00);
        chk("pr_w2_ad", 8'(b.a_d), 8'd1);
        chk("pr_w2_oe", 8'(b.ad_oe), 8'd1);
        go_to(21);
        chk("pr_w2_wr", 8'(b.wr_n), 8'd0);
        go_to(24);
        chk("pr_listo_early", 8'(b.listo), 8'd0);
        go_to(25);
        chk("pr_listo", 8'(b.listo), 8'd1);
        @(negedge clk);
        b.arranque_inicio   = 1'b0;
        b.arranque_leer     = 1'b0;
        b.arranque_escribir = 1'b0;
        go_to(27);
        chk("pr_idle", 8'(b.ocupado), 8'd0);
        go_to(30);
        chk("pr_no_retrigger", 8'(b.ocupado), 8'd0);
        chk("pr_dato_leido", b.dato_leido, 8'hA7);

        // start held past listo: one transaction per IDLE visit
        @(negedge clk);
        b.arranque_escribir = 1'b1;
        b.direccion = 8'h44;
        b.dato      = 8'h11;
        kick();
        go_to(12);
        chk("hold_listo1", 8'(b.listo), 8'd1);
        go_to(13);
        chk("hold_recover_cs", 8'(b.cs_n), 8'd1);
        chk("hold_recover_ocupado", 8'(b.ocupado), 8'd1);
        go_to(14);
        chk("hold_idle_ocupado", 8'(b.ocupado), 8'd0);
        go_to(15);
        chk("hold_restart_cs", 8'(b.cs_n), 8'd0);
        chk("hold_restart_bus", b.ad_out, 8'h44);
        @(negedge clk) b.arranque_escribir = 1'b0;
        go_to(27);
        chk("hold_listo2", 8'(b.listo), 8'd1);
        np = 0;
        while (t < 40) begin
            step();
            if (b.listo) np++;
        end
        chk("hold_extra_listo", 8'(np), 8'd0);
        chk("hold_end_ocupado", 8'(b.ocupado), 8'd0);

        // asynchronous reset during the data strobe
        @(negedge clk);
        b.arranque_escribir = 1'b1;
        b.direccion = 8'h55;
        b.dato      = 8'h66;
        kick();
        @(negedge clk) b.arranque_escribir = 1'b0;
        go_to(8);
        chk("ar_dstb_wr", 8'(b.wr_n), 8'd0);
        chk("ar_dstb_bus", b.ad_out, 8'h66);
        #2 rst = 1'b0;
        #1;
        chk("ar_cs_n", 8'(b.cs_n), 8'd1);
        chk("ar_wr_n", 8'(b.wr_n), 8'd1);
        chk("ar_ad_oe", 8'(b.ad_oe), 8'd0);
        chk("ar_ocupado", 8'(b.ocupado), 8'd0);
        chk("ar_dato_leido", b.dato_leido, 8'h00);
        np = 0;
        repeat (14) begin
            step();
            if (b.listo) np++;
        end
        chk("ar_no_listo", 8'(np), 8'd0);
        @(negedge clk) rst = 1'b1;
        @(negedge clk);
        b.arranque_escribir = 1'b1;
        b.direccion = 8'h33;
        b.dato      = 8'hC3;
        kick();
        chk("ar_after_bus", b.ad_out, 8'h33);
        @(negedge clk) b.arranque_escribir = 1'b0;
        k = 0;
        while (!b.listo && k < 50) begin
            step();
            k++;
        end
        chk("ar_after_latency", 8'(t), 8'd12);
        go_to(14);
        chk("ar_after_idle", 8'(b.ocupado), 8'd0);

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end

endmodule
